// File: rtl/fpmul_arbiter.sv
// Round-robin front end sharing one pipelined FPmul between two requesters,
// with a tag pipe for requester IDs and a credit-guarded FWFT result FIFO.
module fpmul_arbiter #(
  parameter int W     = 32,
  parameter int LAT   = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic         mul_vin,
  input  logic [W-1:0] mul_z,
  input  logic         mul_vout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_id,
  output logic         err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]  cnt;
  logic [CW-1:0]  fcnt;
  logic           last;
  logic           credit;
  logic           grant;
  logic           issue;
  logic           pop;
  logic           wr;
  logic [LAT-1:0] tag_v;
  logic [LAT-1:0] tag_id;
  logic [W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0] id_mem;
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    credit = (cnt < CW'(DEPTH));
    grant  = (req0_valid & req1_valid) ? ~last : req1_valid;
  end

  assign req0_ready = ~grant & req0_valid & credit & ~rst;
  assign req1_ready =  grant & req1_valid & credit & ~rst;
  assign issue      = req0_ready | req1_ready;
  assign mul_vin    = issue;

  // Operands follow the grant only when it actually issues, so idle cycles
  // present requester 0 even if requester 1 is waiting on credit.
  assign mul_a = (issue & grant) ? req1_a : req0_a;
  assign mul_b = (issue & grant) ? req1_b : req0_b;

  assign res_valid = (fcnt != '0);
  assign pop       = res_valid & res_ready;
  assign wr        = tag_v[LAT-1];
  assign res_data  = mem[rptr];
  assign res_id    = id_mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      fcnt   <= '0;
      last   <= 1'b1;
      tag_v  <= '0;
      tag_id <= '0;
      wptr   <= '0;
      rptr   <= '0;
      err    <= 1'b0;
    end else begin
      if (issue & ~pop)
        cnt <= cnt + 1'b1;
      else if (pop & ~issue)
        cnt <= cnt - 1'b1;

      if (issue)
        last <= grant;

      tag_v[0]  <= issue;
      tag_id[0] <= grant;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      if (wr & ~pop)
        fcnt <= fcnt + 1'b1;
      else if (pop & ~wr)
        fcnt <= fcnt - 1'b1;

      if (wr)
        wptr <= ptr_next(wptr);
      if (pop)
        rptr <= ptr_next(rptr);

      if (mul_vout != tag_v[LAT-1])
        err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wptr]    <= mul_z;
      id_mem[wptr] <= tag_id[LAT-1];
    end
  end

endmodule

// File: tb/tb_fpmul_arbiter.sv
// Scoreboard bench for fpmul_arbiter with a behavioural FPmul stand-in.
module tb_fpmul_arbiter;

  localparam int W     = 32;
  localparam int LAT   = 4;
  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_a, req0_b;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_a, req1_b;
  logic [W-1:0] mul_a, mul_b, mul_z;
  logic         mul_vin, mul_vout;
  logic         res_valid, res_ready, res_id, err;
  logic [W-1:0] res_data;

  int n_checks = 0;
  int n_errors = 0;
  int vin_cnt  = 0;
  logic vout_kill = 1'b0;
  logic tb_last;
  logic [32:0] sb [$];

  always #5 clk = ~clk;

  fpmul_arbiter #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_vin(mul_vin), .mul_z(mul_z), .mul_vout(mul_vout),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .err(err)
  );

  // Truncating multiply for normal operands whose product stays normal.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [23:0] ma, mb;
    logic [47:0] p;
    int e;
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]};
    p  = ma * mb;
    e  = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      return {a[31] ^ b[31], e[7:0], p[46:24]};
    end
    return {a[31] ^ b[31], e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    logic [22:0] m;
    e = 8'(100 + $urandom_range(0, 50));
    m = 23'($urandom);
    return {1'($urandom), e, m};
  endfunction

  logic [W-1:0] pz [LAT];
  logic [LAT-1:0] pv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pz[i] <= '0;
    end else begin
      pv[0] <= mul_vin;
      pz[0] <= fmul(mul_a, mul_b);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pz[i] <= pz[i-1];
      end
    end
  end
  assign mul_z    = pz[LAT-1];
  assign mul_vout = pv[LAT-1] & ~vout_kill;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: handshakes push expectations, pops compare against them.
  always @(negedge clk) begin
    logic h0, h1, want;
    logic [32:0] e;
    if (rst) begin
      sb.delete();
      tb_last = 1'b1;
    end else begin
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      if (mul_vin) vin_cnt++;
      if (h0 & h1) check("dual_grant", 1, 0);
      if (h0 | h1) begin
        check("mul_vin", mul_vin, 1);
        check("mul_a", mul_a, h1 ? req1_a : req0_a);
        check("mul_b", mul_b, h1 ? req1_b : req0_b);
        if (req0_valid & req1_valid) begin
          want = tb_last ? 1'b0 : 1'b1;
          check("rr_grant", h1, want);
        end
        tb_last = h1;
        sb.push_back({h1, fmul(h1 ? req1_a : req0_a, h1 ? req1_b : req0_b)});
      end else begin
        check("mul_vin_idle", mul_vin, 0);
        check("mul_a_idle", mul_a, req0_a);
      end
      if (res_valid & res_ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_id", res_id, e[32]);
          check("res_data", res_data, e[31:0]);
        end
      end
    end
  end

  task automatic set0();
    req0_a = rnd_fp();
    req0_b = rnd_fp();
  endtask

  task automatic set1();
    req1_a = rnd_fp();
    req1_b = rnd_fp();
  endtask

  task automatic traffic(input int n0, input int n1, input int budget);
    int r0, r1, cyc;
    logic h0, h1;
    r0 = n0; r1 = n1; cyc = 0;
    @(posedge clk); #1;
    req0_valid = (r0 > 0); if (r0 > 0) set0();
    req1_valid = (r1 > 0); if (r1 > 0) set1();
    while ((r0 > 0 || r1 > 0) && cyc < budget) begin
      @(negedge clk);
      h0 = req0_valid & req0_ready;
      h1 = req1_valid & req1_ready;
      @(posedge clk); #1;
      if (h0) begin r0--; if (r0 > 0) set0(); else req0_valid = 1'b0; end
      if (h1) begin r1--; if (r1 > 0) set1(); else req1_valid = 1'b0; end
      cyc++;
    end
    if (r0 > 0 || r1 > 0) begin
      check("traffic_timeout", r0 + r1, 0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
    end
  endtask

  task automatic stream0(input int n_acc, input int budget, input bit keep);
    int acc, cyc;
    logic h;
    acc = 0; cyc = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; set0();
    while (acc < n_acc && cyc < budget) begin
      @(negedge clk);
      h = req0_valid & req0_ready;
      @(posedge clk); #1;
      if (h) begin
        acc++;
        if (acc < n_acc || keep) set0(); else req0_valid = 1'b0;
      end
      cyc++;
    end
    check("stream_accepts", acc, n_acc);
  endtask

  task automatic wait_drain(input int budget);
    int cyc;
    cyc = 0;
    while ((sb.size() != 0 || res_valid) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    int hi;
    rst = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    // Reset asserted mid-cycle with both requesters valid.
    @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1; set0(); set1();
    @(negedge clk);
    check("pre_rst_ready0", req0_ready, 1);
    check("pre_rst_ready1", req1_ready, 0);
    #1 rst = 1'b1;
    #1;
    check("rst_now_ready0", req0_ready, 0);
    check("rst_now_ready1", req1_ready, 0);
    check("rst_now_vin", mul_vin, 0);
    check("rst_now_res_valid", res_valid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready1", req1_ready, 1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    res_ready = 1'b1;
    wait_drain(40);

    // Single product latency.
    vin_cnt = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_a = 32'h4000_0000; req0_b = 32'h4040_0000;
    @(negedge clk);
    check("single_ready", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      @(negedge clk);
      check("single_early", res_valid, 0);
    end
    @(negedge clk);
    check("single_valid", res_valid, 1);
    check("single_data", res_data, 32'h40C0_0000);
    check("single_id", res_id, 0);
    repeat (2) @(negedge clk);
    check("single_vin_pulses", vin_cnt, 1);

    // Fairness and full-rate streaming.
    traffic(12, 12, 60);
    wait_drain(40);
    check("fair_err", err, 0);

    // Backpressure: exactly DEPTH accepts, then ready low until after a pop.
    res_ready = 1'b0;
    stream0(DEPTH, 30, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("bp_ready_low", req0_ready, 0);
    end
    check("bp_cnt", dut.cnt, DEPTH);
    check("bp_res_valid", res_valid, 1);
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_pop_cycle", req0_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_ready_back", req0_ready, 1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_drain(60);

    // Reset with 3 in flight and 2 queued.
    res_ready = 1'b0;
    stream0(5, 20, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("mf_res_valid", res_valid, 1);
    check("mf_cnt", dut.cnt, 5);
    #1 rst = 1'b1;
    #1;
    check("mf_rst_res_valid", res_valid, 0);
    check("mf_rst_vin", mul_vin, 0);
    @(posedge clk); #1;
    @(negedge clk);
    #1 rst = 1'b0;
    res_ready = 1'b1;
    hi = 0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) hi++;
    end
    check("mf_no_stale", hi, 0);
    traffic(3, 3, 40);
    wait_drain(40);

    // Error: suppress VOUT on a valid last stage.
    check("err_before", err, 0);
    @(posedge clk); #1;
    vout_kill = 1'b1;
    traffic(0, 1, 10);
    repeat (LAT + 2) @(negedge clk);
    check("err_set", err, 1);
    #1 vout_kill = 1'b0;
    wait_drain(40);
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("err_cleared", err, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
